mmio_region_router: RTL and testbench

//  Second-generation MMIO request router between the PCIe MMIO bridge and CSR targets, generalised to NUM_PORTS ports.

---
 rtl/mmio_region_router.sv | 145 ++++++++++++++
 tb/tb_mmio_region_router.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_region_router.sv
// mmio_region_router: MMIO request decode/route to FME, EXT_FME and per-port PORT/EXT_PORT/AFU targets; read timeout enabled by MMIO_TIMEOUT_EN
module mmio_region_router #(
  parameter int NUM_PORTS = 1,
  parameter int TID_WIDTH = 6,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 64,
  parameter logic [2:0] FME_PF = 3'd0,
  parameter logic [3*NUM_PORTS-1:0] PORT_PF_VEC = '0,
  parameter int EXT_FME_START = 'h40,
  parameter int EXT_PORT_START = 'h20,
  parameter int AFU_START = 'h40,
  parameter int AFU_END = 'hC0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_write,
  input  logic [TID_WIDTH-1:0] req_tid,
  input  logic [2:0] req_pf,
  input  logic req_vf_active,
  input  logic [2:0] req_bar,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [3*NUM_PORTS+1:0] tgt_valid,
  input  logic [3*NUM_PORTS+1:0] tgt_ready,
  output logic tgt_write,
  output logic [TID_WIDTH-1:0] tgt_tid,
  output logic [ADDR_WIDTH-1:0] tgt_addr,
  output logic [DATA_WIDTH-1:0] tgt_wdata,
  input  logic [3*NUM_PORTS+1:0] tgt_rsp_valid,
  input  logic [(3*NUM_PORTS+2)*TID_WIDTH-1:0] tgt_rsp_tid,
  input  logic [(3*NUM_PORTS+2)*DATA_WIDTH-1:0] tgt_rsp_data,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic [TID_WIDTH-1:0] rsp_tid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [15:0] err_unmapped_cnt,
  output logic [15:0] err_timeout_cnt,
  output logic err_stray
);
  localparam int NUM_TGT = 2 + 3*NUM_PORTS;
  localparam int IW = $clog2(NUM_TGT);
  localparam int RW = ADDR_WIDTH - 12;
  localparam logic [2:0] FME_BAR = 3'd0;
  localparam logic [2:0] PORT_BAR = 3'd2;
  localparam logic [RW-1:0] EFS = RW'(EXT_FME_START);
  localparam logic [RW-1:0] EPS = RW'(EXT_PORT_START);
  localparam logic [RW-1:0] AFS = RW'(AFU_START);
  localparam logic [RW-1:0] AFE = RW'(AFU_END);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
`ifdef MMIO_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FWD = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RSP = 3'd3;
  localparam logic [2:0] S_UR = 3'd4;
  localparam logic [2:0] S_TMO = 3'd5;
  logic [2:0] state;
  logic [IW-1:0] idx, dec_idx;
  logic dec_hit, hit, tmo;
  logic [RW-1:0] region;
  logic [NUM_TGT-1:0] sel;
  logic [15:0] tmo_cnt;
  assign region = req_addr[ADDR_WIDTH-1:12];
  assign sel = NUM_TGT'(1) << idx;
  assign req_ready = rst_n && state == S_IDLE;
  assign tgt_valid = state == S_FWD ? sel : '0;
  assign rsp_valid = state == S_RSP || state == S_UR || state == S_TMO;
  assign hit = tgt_rsp_valid[idx] && tgt_rsp_tid[idx*TID_WIDTH +: TID_WIDTH] == tgt_tid;
  assign tmo = TMO_EN && state == S_WAIT && !hit && tmo_cnt == TMO_LAST;
  // Decode target: FME wins, otherwise the lowest-numbered matching port decides by region
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--)
      if (!req_vf_active && req_bar == PORT_BAR && req_pf == PORT_PF_VEC[3*p +: 3]) begin
        dec_hit = region < AFE;
        dec_idx = region < EPS ? IW'(2 + 3*p) : region < AFS ? IW'(3 + 3*p) : IW'(4 + 3*p);
      end
    if (!req_vf_active && req_bar == FME_BAR && req_pf == FME_PF) begin
      dec_hit = 1'b1;
      dec_idx = region >= EFS ? IW'(1) : IW'(0);
    end
  end
  // Request/response FSM with held target fields and completion registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      idx <= '0;
      tgt_write <= 1'b0;
      tgt_tid <= '0;
      tgt_addr <= '0;
      tgt_wdata <= '0;
      rsp_tid <= '0;
      rsp_data <= '0;
    end else
      case (state)
        S_IDLE: if (req_valid) begin
          idx <= dec_idx;
          tgt_write <= req_write;
          tgt_tid <= req_tid;
          tgt_addr <= req_addr;
          tgt_wdata <= req_wdata;
          if (dec_hit) state <= S_FWD;
          else if (!req_write) begin
            state <= S_UR;
            rsp_tid <= req_tid;
            rsp_data <= '1;
          end
        end
        S_FWD: if (tgt_ready[idx]) state <= tgt_write ? S_IDLE : S_WAIT;
        S_WAIT: if (hit) begin
          state <= S_RSP;
          rsp_tid <= tgt_tid;
          rsp_data <= tgt_rsp_data[idx*DATA_WIDTH +: DATA_WIDTH];
        end else if (tmo) begin
          state <= S_TMO;
          rsp_tid <= tgt_tid;
          rsp_data <= '1;
        end
        S_RSP, S_UR, S_TMO: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
  // Read timeout counter, cleared whenever not waiting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_cnt <= '0;
    else tmo_cnt <= TMO_EN && state == S_WAIT ? tmo_cnt + 16'd1 : '0;
  // Error counters and sticky stray flag; only the matching response in WAIT is not stray
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_unmapped_cnt <= '0;
      err_timeout_cnt <= '0;
      err_stray <= 1'b0;
    end else begin
      err_unmapped_cnt <= state == S_IDLE && req_valid && !dec_hit && ~&err_unmapped_cnt ? err_unmapped_cnt + 16'd1 : err_unmapped_cnt;
      err_timeout_cnt <= tmo && ~&err_timeout_cnt ? err_timeout_cnt + 16'd1 : err_timeout_cnt;
      err_stray <= err_stray | (|(tgt_rsp_valid & ~(state == S_WAIT && hit ? sel : '0)));
    end
endmodule

// File: tb/tb_mmio_region_router.sv
// tb_mmio_region_router: table-driven and randomized checks of mmio_region_router
module tb_mmio_region_router;
  localparam int NT = 5;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0, req_vf_active = 1'b0;
  logic [5:0] req_tid = '0;
  logic [2:0] req_pf = '0, req_bar = '0;
  logic [19:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [NT-1:0] tgt_valid, tgt_ready = '0, tgt_rsp_valid = '0;
  logic tgt_write;
  logic [5:0] tgt_tid;
  logic [19:0] tgt_addr;
  logic [63:0] tgt_wdata;
  logic [NT*6-1:0] tgt_rsp_tid = '0;
  logic [NT*64-1:0] tgt_rsp_data = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [5:0] rsp_tid;
  logic [63:0] rsp_data;
  logic [15:0] err_unmapped_cnt, err_timeout_cnt;
  logic err_stray;
  int checks = 0, failures = 0, exp_unm = 0;

  mmio_region_router #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_tid(req_tid), .req_pf(req_pf),
    .req_vf_active(req_vf_active), .req_bar(req_bar), .req_addr(req_addr),
    .req_wdata(req_wdata), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_write(tgt_write), .tgt_tid(tgt_tid), .tgt_addr(tgt_addr),
    .tgt_wdata(tgt_wdata), .tgt_rsp_valid(tgt_rsp_valid), .tgt_rsp_tid(tgt_rsp_tid),
    .tgt_rsp_data(tgt_rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_tid(rsp_tid), .rsp_data(rsp_data), .err_unmapped_cnt(err_unmapped_cnt),
    .err_timeout_cnt(err_timeout_cnt), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic w;
    logic [2:0] pf;
    logic vf;
    logic [2:0] bar;
    logic [19:0] addr;
    logic [5:0] tid;
    logic [63:0] d;
    int rdy_dly;
    int rsp_dly;
    int exp_idx;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: target index from the address map, -1 when unmapped
  function automatic int model_idx(input logic [2:0] pf, input logic vf, input logic [2:0] bar, input logic [19:0] addr);
    int r;
    r = int'(addr) / 4096;
    if (vf || pf != 3'd0) return -1;
    if (bar == 3'd0) return r >= 64 ? 1 : 0;
    if (bar == 3'd2) return r < 32 ? 2 : r < 64 ? 3 : r < 192 ? 4 : -1;
    return -1;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".req_ready"}, req_ready, 1);
  endtask

  task automatic accept(input logic w, input logic [2:0] pf, input logic vf, input logic [2:0] bar,
                        input logic [19:0] addr, input logic [5:0] tid, input logic [63:0] d, input string tag);
    wait_ready(tag);
    req_write = w; req_pf = pf; req_vf_active = vf; req_bar = bar;
    req_addr = addr; req_tid = tid; req_wdata = d; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp(input int dly, input logic [63:0] d, input logic [5:0] tid, input string tag);
    repeat (dly) begin
      tick();
      check({tag, ".rsp_hold"}, {rsp_valid, rsp_tid, rsp_data[56:0]}, {1'b1, tid, d[56:0]});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, ".rsp_drop"}, rsp_valid, 0);
    check({tag, ".req_ready_back"}, req_ready, 1);
  endtask

  task automatic respond(input int i, input logic [5:0] tid, input logic [63:0] d);
    tgt_rsp_valid = NT'(1) << i;
    tgt_rsp_tid[i*6 +: 6] = tid;
    tgt_rsp_data[i*64 +: 64] = d;
    tick();
    tgt_rsp_valid = '0;
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    accept(v.w, v.pf, v.vf, v.bar, v.addr, v.tid, v.d, tag);
    if (v.exp_idx < 0) begin
      exp_unm++;
      check({tag, ".unm_cnt"}, err_unmapped_cnt, 64'(exp_unm));
      check({tag, ".ur_strobe"}, tgt_valid, 0);
      if (v.w) begin
        check({tag, ".ur_w_rsp"}, rsp_valid, 0);
        check({tag, ".ur_w_ready"}, req_ready, 1);
      end else begin
        check({tag, ".ur_rsp"}, {rsp_valid, rsp_tid}, {1'b1, v.tid});
        check({tag, ".ur_data"}, rsp_data, '1);
        finish_rsp(v.rsp_dly, '1, v.tid, tag);
      end
      return;
    end
    check({tag, ".tgt_valid"}, tgt_valid, 64'(1) << v.exp_idx);
    check({tag, ".tgt_fields"}, {tgt_write, tgt_tid, tgt_addr}, {v.w, v.tid, v.addr});
    if (v.w) check({tag, ".tgt_wdata"}, tgt_wdata, v.d);
    tgt_ready = ~(NT'(1) << v.exp_idx);
    repeat (v.rdy_dly) begin
      tick();
      check({tag, ".tgt_hold"}, {tgt_valid, tgt_addr}, {NT'(1) << v.exp_idx, v.addr});
    end
    tgt_ready = '1;
    tick();
    tgt_ready = '0;
    check({tag, ".tgt_done"}, tgt_valid, 0);
    if (v.w) begin
      check({tag, ".w_no_rsp"}, rsp_valid, 0);
      check({tag, ".w_ready"}, req_ready, 1);
      return;
    end
    check({tag, ".wait_no_rsp"}, rsp_valid, 0);
    respond(v.exp_idx, v.tid, v.d);
    check({tag, ".rsp"}, {rsp_valid, rsp_tid}, {1'b1, v.tid});
    check({tag, ".rsp_data"}, rsp_data, v.d);
    finish_rsp(v.rsp_dly, v.d, v.tid, tag);
  endtask

  // Accept a read and complete the target handshake immediately, leaving the DUT waiting
  task automatic start_read(input logic [2:0] bar, input logic [19:0] addr, input logic [5:0] tid, input string tag);
    accept(1'b0, 3'd0, 1'b0, bar, addr, tid, '0, tag);
    tgt_ready = '1;
    tick();
    tgt_ready = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst.req_ready", req_ready, 0);
    check("rst.outs", {tgt_valid, rsp_valid, rsp_tid}, 0);
    check("rst.rsp_data", rsp_data, 0);
    check("rst.errs", {err_unmapped_cnt, err_timeout_cnt, err_stray}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst.ready_after", req_ready, 1);
    exp_unm = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    int n;
    vecs[0]  = '{1'b0, 3'd0, 1'b0, 3'd0, 20'h00010, 6'd3,  64'hA5, 0, 0, 0};
    vecs[1]  = '{1'b0, 3'd0, 1'b0, 3'd0, 20'h40000, 6'd4,  64'h1234, 0, 1, 1};
    vecs[2]  = '{1'b0, 3'd0, 1'b0, 3'd0, 20'h3F008, 6'd5,  64'hBEEF, 1, 0, 0};
    vecs[3]  = '{1'b1, 3'd0, 1'b0, 3'd2, 20'h41000, 6'd6,  64'hCAFE, 5, 0, 4};
    vecs[4]  = '{1'b0, 3'd0, 1'b0, 3'd2, 20'h1F000, 6'd8,  64'h22, 0, 0, 2};
    vecs[5]  = '{1'b0, 3'd0, 1'b0, 3'd2, 20'h20000, 6'd9,  64'h33, 0, 2, 3};
    vecs[6]  = '{1'b0, 3'd0, 1'b0, 3'd2, 20'hBF000, 6'd10, 64'h44, 0, 0, 4};
    vecs[7]  = '{1'b0, 3'd0, 1'b0, 3'd2, 20'hC0000, 6'd11, 64'h0, 0, 0, -1};
    vecs[8]  = '{1'b0, 3'd0, 1'b0, 3'd4, 20'h00010, 6'd7,  64'h0, 0, 0, -1};
    vecs[9]  = '{1'b0, 3'd0, 1'b1, 3'd0, 20'h00010, 6'd7,  64'h0, 0, 3, -1};
    vecs[10] = '{1'b1, 3'd1, 1'b0, 3'd0, 20'h00020, 6'd1,  64'h55, 0, 0, -1};
    vecs[11] = '{1'b1, 3'd0, 1'b0, 3'd0, 20'h00100, 6'd2,  64'h66, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 12; i++) do_txn(vecs[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 40; i++) begin
      rv.w = 1'($urandom_range(0, 1));
      rv.pf = $urandom_range(0, 3) == 0 ? 3'd1 : 3'd0;
      rv.vf = $urandom_range(0, 7) == 0;
      rv.bar = $urandom_range(0, 2) == 0 ? 3'($urandom_range(0, 7)) : ($urandom_range(0, 1) == 0 ? 3'd0 : 3'd2);
      rv.addr = 20'($urandom) & 20'hFFFF8;
      rv.tid = 6'($urandom);
      rv.d = {$urandom, $urandom};
      rv.rdy_dly = $urandom_range(0, 3);
      rv.rsp_dly = $urandom_range(0, 2);
      rv.exp_idx = model_idx(rv.pf, rv.vf, rv.bar, rv.addr);
      do_txn(rv, $sformatf("rnd%0d", i));
    end
    check("stray.before", err_stray, 0);
    start_read(3'd2, 20'h20000, 6'd9, "stray");
    respond(1, 6'd9, 64'h111);
    check("stray.wrong_idx", {err_stray, rsp_valid}, 2'b10);
    respond(3, 6'd9, 64'h333);
    check("stray.rsp", {rsp_valid, rsp_tid}, {1'b1, 6'd9});
    check("stray.data", rsp_data, 64'h333);
    finish_rsp(0, 64'h333, 6'd9, "stray");
    start_read(3'd0, 20'h00010, 6'd5, "rstwait");
    check("rstwait.waiting", {rsp_valid, req_ready}, 0);
    do_reset();
    do_txn(vecs[0], "post_rst");
`ifdef MMIO_TIMEOUT_EN
    start_read(3'd2, 20'h41000, 6'd12, "tmo");
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    check("tmo.cycles", n, 16);
    check("tmo.rsp", {rsp_valid, rsp_tid, err_timeout_cnt}, {1'b1, 6'd12, 16'd1});
    check("tmo.data", rsp_data, '1);
    check("tmo.no_stray", err_stray, 0);
    finish_rsp(0, '1, 6'd12, "tmo");
    respond(4, 6'd12, 64'h77);
    check("tmo.late_stray", err_stray, 1);
`else
    start_read(3'd2, 20'h41000, 6'd12, "notmo");
    repeat (40) tick();
    check("notmo.still_wait", {rsp_valid, err_timeout_cnt}, 0);
    respond(4, 6'd12, 64'h77);
    check("notmo.rsp", {rsp_valid, rsp_data}, {1'b1, 64'h77});
    finish_rsp(0, 64'h77, 6'd12, "notmo");
`endif
    do_reset();
    start_read(3'd0, 20'h00010, 6'd5, "tidmm");
    respond(0, 6'd6, 64'h99);
    check("tidmm.stray", {err_stray, rsp_valid}, 2'b10);
    respond(0, 6'd5, 64'hAB);
    check("tidmm.rsp", {rsp_valid, rsp_tid, rsp_data}, {1'b1, 6'd5, 64'hAB});
    finish_rsp(1, 64'hAB, 6'd5, "tidmm");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
